alu_seq: RTL and testbench

- Parametrised, handshaked successor to the core single-cycle ALU.
- Adds shifts, signed and unsigned compares, and iterative multiply/divide/remainder.
- Sits in the execute stage and stalls the pipeline through valid/ready on both sides.
- One operation is in flight at a time. Single-cycle ops have 1-cycle latency; MUL/DIV/REM take WIDTH+1 cycles.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 79 +++++++
 rtl/alu_seq.sv | 111 +++++++++++
 tb/tb_alu_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states, op classification.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_REMU  = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aluState_t;

  // Ops that go through the iterative mul/div datapath
  function automatic logic isMultiCycle(aluOp_t op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one register set.
// done/res are combinational: done marks the edge that performs the last step,
// and res is the value that step produces, so the parent can latch it directly.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  aluOp_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  logic             r_act;
  logic [SHW-1:0]   r_cnt;
  aluOp_t           r_op;
  logic [WIDTH-1:0] r_acc;  // partial product / partial remainder
  logic [WIDTH-1:0] r_md;   // multiplicand (shifts left) / divisor
  logic [WIDTH-1:0] r_q;    // multiplier (shifts right) / dividend-in, quotient-out

  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nx, w_md_nx, w_q_nx;

  // One iteration step; the remainder shift needs WIDTH+1 bits before the compare
  always_comb begin
    w_sh  = {r_acc, r_q[WIDTH-1]};
    w_sub = w_sh[WIDTH-1:0] - r_md;
    w_ge  = (w_sh >= {1'b0, r_md});
    if (r_op == OP_MUL) begin
      w_acc_nx = r_q[0] ? (r_acc + r_md) : r_acc;
      w_md_nx  = r_md << 1;
      w_q_nx   = r_q >> 1;
    end else begin
      w_acc_nx = w_ge ? w_sub : w_sh[WIDTH-1:0];
      w_md_nx  = r_md;
      w_q_nx   = {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign done = r_act && (r_cnt == SHW'(WIDTH-1));
  assign res  = (r_op == OP_DIVU) ? w_q_nx : w_acc_nx;

  // Load on start, then step once per cycle for WIDTH cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= 1'b0;
      r_cnt <= '0;
      r_op  <= OP_ADD;
      r_acc <= '0;
      r_md  <= '0;
      r_q   <= '0;
    end else if (start) begin
      r_act <= 1'b1;
      r_cnt <= '0;
      r_op  <= op;
      r_acc <= '0;
      r_md  <= (op == OP_MUL) ? a : b;
      r_q   <= (op == OP_MUL) ? b : a;
    end else if (r_act) begin
      r_acc <= w_acc_nx;
      r_md  <= w_md_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_act <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops plus iterative MUL/DIVU/REMU,
// one operation in flight, result held in DONE until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluOp_t           aluOp,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  aluState_t        r_state, w_state_nx;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_hs, w_multi, w_start, w_done;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sc, w_it_res;

  assign w_hs    = inValid && (r_state == IDLE);
  assign w_multi = isMultiCycle(aluOp);
  assign w_start = w_hs && w_multi;
  assign w_shamt = b[SHW-1:0];

  // Single-cycle datapath, evaluated on the live operands at the handshake
  always_comb begin
    w_sc = '0;
    case (aluOp)
      OP_ADD:  w_sc = a + b;
      OP_SUB:  w_sc = a - b;
      OP_AND:  w_sc = a & b;
      OP_OR:   w_sc = a | b;
      OP_XOR:  w_sc = a ^ b;
      OP_SLL:  w_sc = a << w_shamt;
      OP_SRL:  w_sc = a >> w_shamt;
      OP_SRA:  w_sc = $signed(a) >>> w_shamt;
      OP_SLT:  w_sc = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_sc = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_sc = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .op    (aluOp),
    .a     (a),
    .b     (b),
    .done  (w_done),
    .res   (w_it_res)
  );

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nx = r_state;
    inReady    = 1'b0;
    outValid   = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) w_state_nx = w_multi ? BUSY : DONE;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_done) w_state_nx = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Output registers: load on single-cycle accept or final iteration, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_hs && !w_multi) begin
      r_result <= w_sc;
      r_zero   <= (w_sc == '0);
    end else if ((r_state == BUSY) && w_done) begin
      r_result <= w_it_res;
      r_zero   <= (w_it_res == '0);
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes expected responses computed by
// a plain-arithmetic reference model; a monitor pops and checks on each output.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] a = '0, b = '0;
  aluOp_t       aluOp = OP_ADD;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .a(a), .b(b), .aluOp(aluOp), .outValid(outValid), .outReady(outReady),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           op;
    logic [W-1:0] res;
    int           lat;
    int           busyc;
    int           acc;
    int           hold;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the op definitions
  function automatic logic [W-1:0] model(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned  sh;
    logic [2*W-1:0] p;
    sh = y % W;
    p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (op)
      0:  return x + y;
      1:  return x - y;
      2:  return x & y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return x << sh;
      6:  return x >> sh;
      7:  return $signed(x) >>> sh;
      8:  return ($signed(x) < $signed(y)) ? 1 : 0;
      9:  return (x < y) ? 1 : 0;
      10: return p[W-1:0];
      11: return (y == 0) ? {W{1'b1}} : x / y;
      12: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return {W{1'b1}};
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 300);
      default: return $urandom;
    endcase
  endfunction

  // Wait for inReady (pulsing junk requests meanwhile), then issue one request
  task automatic issue(input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold, input bit push);
    exp_t e;
    int   n = 0;
    bit   multi;
    @(negedge clk);
    while (!inReady || ($urandom_range(0, 3) == 0)) begin
      inValid = inReady ? 1'b0 : 1'($urandom_range(0, 1));
      a       = $urandom;
      b       = $urandom;
      aluOp   = aluOp_t'($urandom_range(0, 15));
      n++;
      if (n > 300) begin
        chk("issue_timeout", inReady, 1);
        return;
      end
      @(negedge clk);
    end
    multi   = (op == 10) || (op == 11) || (op == 12);
    inValid = 1'b1;
    aluOp   = aluOp_t'(op);
    a       = x;
    b       = y;
    if (push) begin
      e.op    = op;
      e.res   = model(op, x, y);
      e.lat   = multi ? W + 1 : 1;
      e.busyc = multi ? W : 0;
      e.acc   = cyc + 1;
      e.hold  = hold;
      q.push_back(e);
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: drives outReady, checks latency, stability, result and zero
  initial begin
    bit           seen = 0;
    bit           chk_ready = 0;
    int           hold_left = 0;
    int           busy_cnt = 0;
    logic [W-1:0] held_res;
    logic         held_z;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outReady  = 1'b0;
        seen      = 0;
        chk_ready = 0;
        busy_cnt  = 0;
        continue;
      end
      if (chk_ready) begin
        chk("inReady_after_take", inReady, 1);
        chk_ready = 0;
      end
      if (busy) begin
        busy_cnt++;
        chk("inReady_low_in_busy", inReady, 0);
      end
      outReady = 1'b0;
      if (outValid) begin
        if (q.size() == 0) begin
          chk("unexpected_outValid", outValid, 0);
        end else begin
          if (!seen) begin
            seen      = 1;
            hold_left = q[0].hold;
            held_res  = result;
            held_z    = zero;
            chk($sformatf("latency_op%0d", q[0].op), cyc + 1 - q[0].acc, q[0].lat);
            chk($sformatf("busy_cycles_op%0d", q[0].op), busy_cnt, q[0].busyc);
            chk("inReady_low_in_done", inReady, 0);
          end else begin
            chk("held_stable", {result, zero}, {held_res, held_z});
          end
          if (hold_left > 0) begin
            hold_left--;
          end else begin
            outReady = 1'b1;
            chk($sformatf("result_op%0d", q[0].op), result, q[0].res);
            chk($sformatf("zero_op%0d", q[0].op), zero, (q[0].res == 0));
            void'(q.pop_front());
            seen      = 0;
            busy_cnt  = 0;
            chk_ready = 1;
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int           d_op[13]   = '{0, 7, 8, 9, 10, 11, 12, 11, 12, 4, 10, 13, 1};
  logic [W-1:0] d_a[13]    = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h0001_2345, 32'd100, 32'd100, 32'd5, 32'd5, 32'hF0F0_F0F0,
                               32'hFFFF_FFFF, 32'h1234_5678, 32'd0};
  logic [W-1:0] d_b[13]    = '{32'd1, 32'h24, 32'd1, 32'd1, 32'h100, 32'd7, 32'd7, 32'd0,
                               32'd0, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'd1};
  int           d_hold[13] = '{0, 0, 1, 0, 0, 0, 2, 0, 0, 10, 0, 0, 3};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 1);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Directed vectors from the test plan plus a few edge cases
    for (int i = 0; i < 13; i++) issue(d_op[i], d_a[i], d_b[i], d_hold[i], 1);
    drain();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 70; i++)
      issue($urandom_range(0, 15), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3), 1);
    drain();

    // Reset 10 cycles into a DIVU: nothing must come out afterwards
    issue(11, 32'd1000, 32'd3, 0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outValid", outValid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_inReady", inReady, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("postrst_inReady", inReady, 1);
    chk("postrst_outValid", outValid, 0);
    repeat (40) @(negedge clk);
    chk("postrst_no_stale", outValid, 0);
    issue(0, 32'd2, 32'd3, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
